// File: rtl/bindct_2d_ctrl_if.sv
// Row input, 1-D core operand/result and column output bundle of the 2-D binDCT sequencer.
// The sequencer side uses the slave modport; source, core and sink together form the master side.
interface bindct_2d_ctrl_if #(
   parameter int NUM_SIZE = 8,
   parameter int FP_SIZE  = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [8*NUM_SIZE-1:0] in_row;
   logic [8*FP_SIZE-1:0]  core_x_in;
   logic [8*FP_SIZE-1:0]  core_x_out;
   logic                  out_valid;
   logic [8*FP_SIZE-1:0]  out_col;
   logic [2:0]            out_idx;
   logic                  out_last;
   logic                  busy;
   logic                  done;

   modport slave (
      input  in_valid, in_row, core_x_out,
      output in_ready, core_x_in, out_valid, out_col, out_idx, out_last, busy, done
   );

   modport master (
      output in_valid, in_row, core_x_out,
      input  in_ready, core_x_in, out_valid, out_col, out_idx, out_last, busy, done
   );
endinterface

// File: rtl/bindct_2d_ctrl.sv
// 8x8 2-D DCT sequencer: runs rows then columns through one shared external 1-D core,
// keeping the row results in an internal transpose buffer.
module bindct_2d_ctrl #(
   parameter int NUM_SIZE = 8,
   parameter int FP_SIZE  = 32,
   parameter int FRAC     = 12,
   parameter int CORE_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   bindct_2d_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ROW, ROW_WAIT, COL, COL_WAIT} state_e;
   typedef struct packed {
      logic       v;
      logic       col;
      logic [2:0] idx;
   } tag_t;
   localparam int TAIL = CORE_LAT - 1;

   state_e                   state_q, state_d;
   logic [3:0]               rcnt_q, rcnt_d;
   logic [2:0]               ccnt_q, ccnt_d;
   tag_t [CORE_LAT-1:0]      tag_q;
   tag_t                     issue;
   logic                     in_ready, accept, pend;
   logic                     out_valid_q, out_last_q, done_q;
   logic [7:0][FP_SIZE-1:0]  out_col_q;
   logic [2:0]               out_idx_q;
   logic [FP_SIZE-1:0]       tbuf_q [8][8];
   logic [7:0][FP_SIZE-1:0]  row_x, col_x, res;

   assign res            = bus.core_x_out;
   assign bus.in_ready   = in_ready;
   assign bus.core_x_in  = (state_q == COL) ? col_x : row_x;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_col    = out_col_q;
   assign bus.out_idx    = out_idx_q;
   assign bus.out_last   = out_last_q;
   assign bus.done       = done_q;
   assign bus.busy       = (state_q != IDLE);

   always_comb begin
      for (int n = 0; n < 8; n++)
         row_x[n] = {{(FP_SIZE-NUM_SIZE){bus.in_row[n*NUM_SIZE+NUM_SIZE-1]}},
                     bus.in_row[n*NUM_SIZE +: NUM_SIZE]} << FRAC;
      for (int r = 0; r < 8; r++)
         col_x[r] = tbuf_q[r][ccnt_q];
   end

   always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      ccnt_d   = ccnt_q;
      issue    = '0;
      in_ready = 1'b0;
      // Only the tail may still be pending: it lands in the buffer at this edge.
      pend     = 1'b0;
      for (int i = 0; i < TAIL; i++) pend = pend | tag_q[i].v;
      if (state_q == IDLE)     in_ready = rst;
      else if (state_q == ROW) in_ready = rst && (rcnt_q < 4'd8);
      accept = bus.in_valid && in_ready;
      case (state_q)
         IDLE: if (accept) begin
            issue   = '{v: 1'b1, col: 1'b0, idx: 3'd0};
            rcnt_d  = 4'd1;
            state_d = ROW;
         end
         ROW: if (accept) begin
            issue  = '{v: 1'b1, col: 1'b0, idx: rcnt_q[2:0]};
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q == 4'd7) state_d = ROW_WAIT;
         end
         ROW_WAIT: if (!pend) begin
            ccnt_d  = 3'd0;
            state_d = COL;
         end
         COL: begin
            issue  = '{v: 1'b1, col: 1'b1, idx: ccnt_q};
            ccnt_d = ccnt_q + 3'd1;
            if (ccnt_q == 3'd7) state_d = COL_WAIT;
         end
         COL_WAIT: if (done_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         rcnt_q      <= '0;
         ccnt_q      <= '0;
         tag_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         out_col_q   <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q  <= state_d;
         rcnt_q   <= rcnt_d;
         ccnt_q   <= ccnt_d;
         tag_q[0] <= issue;
         for (int i = 1; i < CORE_LAT; i++) tag_q[i] <= tag_q[i-1];
         out_valid_q <= tag_q[TAIL].v && tag_q[TAIL].col;
         out_last_q  <= tag_q[TAIL].v && tag_q[TAIL].col && (tag_q[TAIL].idx == 3'd7);
         done_q      <= out_last_q;
         if (tag_q[TAIL].v && tag_q[TAIL].col) begin
            out_col_q <= res;
            out_idx_q <= tag_q[TAIL].idx;
         end
      end
   end

   // Row index comes from the tag, so input stalls never skew the buffer row.
   always_ff @(posedge clk) begin
      if (rst && tag_q[TAIL].v && !tag_q[TAIL].col)
         for (int k = 0; k < 8; k++) tbuf_q[tag_q[TAIL].idx][k] <= res[k];
   end
endmodule

// File: tb/tb_bindct_2d_ctrl.sv
// Bench for bindct_2d_ctrl: two instances (core latency 1 and 3), each with a behavioural integer
// 1-D transform core; outputs checked against the direct 2-D transform of each block.
module tb_bindct_2d_ctrl;
   localparam int NS = 8;
   localparam int FP = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic vld = 1'b0;
   logic sel = 1'b0;
   logic [8*NS-1:0] row = '0;
   int cyc = 0;
   int nvec = 0;
   int nerr = 0;
   int blk [8][8];
   int acc0_cyc, done_cyc;
   logic [31:0] cap_dc;

   // Integer 8-point transform: row 0 sums, other rows sum to zero, deliberately not symmetric.
   int C [8][8] = '{
      '{ 1,   1,   1,   1,   1,   1,   1,   1},
      '{12,  10,   6,   3,  -3,  -6, -10, -12},
      '{ 8,   4,  -4,  -8,  -8,  -4,   4,   8},
      '{10,  -3, -12,  -6,   6,  12,   3, -10},
      '{ 8,  -8,  -8,   8,   8,  -8,  -8,   8},
      '{ 6, -12,   3,  10, -10,  -3,  12,  -6},
      '{ 4,  -8,   8,  -4,  -4,   8,  -8,   4},
      '{ 3,  -6,  10, -12,  12, -10,   6,  -3}};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bindct_2d_ctrl_if #(.NUM_SIZE(NS), .FP_SIZE(FP)) bus1 ();
   bindct_2d_ctrl_if #(.NUM_SIZE(NS), .FP_SIZE(FP)) bus3 ();

   bindct_2d_ctrl #(.NUM_SIZE(NS), .FP_SIZE(FP), .FRAC(12), .CORE_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1));
   bindct_2d_ctrl #(.NUM_SIZE(NS), .FP_SIZE(FP), .FRAC(12), .CORE_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .bus(bus3));

   assign bus1.in_valid = vld & ~sel;
   assign bus3.in_valid = vld & sel;
   assign bus1.in_row   = row;
   assign bus3.in_row   = row;

   function automatic logic [8*FP-1:0] core_f(input logic [8*FP-1:0] x);
      logic [8*FP-1:0] y;
      int acc;
      y = '0;
      for (int k = 0; k < 8; k++) begin
         acc = 0;
         for (int n = 0; n < 8; n++) acc += C[k][n] * int'(signed'(x[n*FP +: FP]));
         y[k*FP +: FP] = acc;
      end
      return y;
   endfunction

   logic [8*FP-1:0] cp1;
   logic [8*FP-1:0] cp3 [3];
   always @(posedge clk) begin
      cp1    <= core_f(bus1.core_x_in);
      cp3[0] <= core_f(bus3.core_x_in);
      cp3[1] <= cp3[0];
      cp3[2] <= cp3[1];
   end
   assign bus1.core_x_out = cp1;
   assign bus3.core_x_out = cp3[2];

   logic m_ready, m_ov, m_last, m_done, m_busy;
   logic [8*FP-1:0] m_col;
   logic [2:0] m_idx;
   assign m_ready = sel ? bus3.in_ready  : bus1.in_ready;
   assign m_ov    = sel ? bus3.out_valid : bus1.out_valid;
   assign m_last  = sel ? bus3.out_last  : bus1.out_last;
   assign m_done  = sel ? bus3.done      : bus1.done;
   assign m_busy  = sel ? bus3.busy      : bus1.busy;
   assign m_col   = sel ? bus3.out_col   : bus1.out_col;
   assign m_idx   = sel ? bus3.out_idx   : bus1.out_idx;

   // Y[k][c] = sum_r sum_n C[k][r] * C[c][n] * x[r][n], inputs scaled by 2^12.
   function automatic int ref_y(input int k, input int c);
      int s;
      s = 0;
      for (int r = 0; r < 8; r++)
         for (int n = 0; n < 8; n++) s += C[k][r] * C[c][n] * blk[r][n];
      return s * 4096;
   endfunction

   function automatic logic [8*NS-1:0] pack_row(input int r);
      logic [8*NS-1:0] v;
      for (int n = 0; n < 8; n++) v[n*NS +: NS] = 8'(blk[r][n]);
      return v;
   endfunction

   task automatic fill(input bit rnd, input int v);
      for (int r = 0; r < 8; r++)
         for (int n = 0; n < 8; n++)
            blk[r][n] = rnd ? int'($urandom_range(0, 255)) - 128 : v;
   endtask

   // gap: 0 = in_valid held, 1 = 1,0,0 pattern, 2 = random
   task automatic run_block(input int gap);
      int r, t, bud, beats, first_ov, last_ov;
      bit got_done;
      r = 0; t = 0; bud = 200;
      while (r < 8 && bud > 0) begin
         case (gap)
            0:       vld = 1'b1;
            1:       vld = (t % 3 == 0);
            default: vld = 1'($urandom_range(0, 1));
         endcase
         row = pack_row(r);
         if (vld && m_ready) begin
            if (r == 0) acc0_cyc = cyc;
            r++;
         end
         t++; bud--;
         @(posedge clk); @(negedge clk);
      end
      vld = 1'b0;
      nvec++;
      if (r != 8) begin nerr++; $display("FAIL accept_rows: got %0d rows, need 8", r); end
      beats = 0; got_done = 1'b0; bud = 200; first_ov = 0; last_ov = 0;
      while (!got_done && bud > 0) begin
         nvec++;
         if (m_ready !== 1'b0) begin nerr++; $display("FAIL ready_low: in_ready=%b at cyc %0d, need 0", m_ready, cyc); end
         nvec++;
         if (m_busy !== 1'b1) begin nerr++; $display("FAIL busy: busy=%b at cyc %0d, need 1", m_busy, cyc); end
         if (m_ov === 1'b1) begin
            nvec++;
            if (m_idx !== 3'(beats)) begin nerr++; $display("FAIL out_idx: got %0d, need %0d", m_idx, beats); end
            for (int k = 0; k < 8; k++) begin
               nvec++;
               if (m_col[k*FP +: FP] !== 32'(ref_y(k, beats & 7))) begin
                  nerr++;
                  $display("FAIL out_col[%0d] col %0d: got %h, need %h", k, beats, m_col[k*FP +: FP], 32'(ref_y(k, beats & 7)));
               end
            end
            nvec++;
            if (m_last !== (beats == 7)) begin nerr++; $display("FAIL out_last: got %b at col %0d", m_last, beats); end
            if (beats == 0) begin
               first_ov = cyc;
               cap_dc = m_col[31:0];
            end else begin
               nvec++;
               if (cyc != first_ov + beats) begin nerr++; $display("FAIL burst_gap: col %0d at cyc %0d, need %0d", beats, cyc, first_ov + beats); end
            end
            beats++;
            last_ov = cyc;
         end
         if (m_done === 1'b1) begin
            got_done = 1'b1;
            done_cyc = cyc;
            nvec++;
            if (beats != 8) begin nerr++; $display("FAIL beat_count: got %0d out_valid cycles, need 8", beats); end
            nvec++;
            if (cyc != last_ov + 1) begin nerr++; $display("FAIL done_timing: done at cyc %0d, need %0d", cyc, last_ov + 1); end
         end else begin
            @(posedge clk); @(negedge clk);
            bud--;
         end
      end
      nvec++;
      if (!got_done) begin nerr++; $display("FAIL done_timeout: no done pulse, got %0d columns", beats); end
   endtask

   task automatic test_reset;
      rst = 1'b0; vld = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      nvec++;
      if (m_ready !== 1'b0 || bus3.in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b/%b, need 0/0", m_ready, bus3.in_ready); end
      nvec++;
      if ({m_ov, m_last, m_done, m_busy} !== 4'b0) begin nerr++; $display("FAIL rst_flags: got %b, need 0000", {m_ov, m_last, m_done, m_busy}); end
      nvec++;
      if (m_idx !== 3'd0 || m_col !== '0) begin nerr++; $display("FAIL rst_data: idx %0d col %h, need 0", m_idx, m_col); end
      rst = 1'b1;
      #1;
      nvec++;
      if (m_ready !== 1'b1) begin nerr++; $display("FAIL idle_ready: got %b, need 1", m_ready); end
      @(negedge clk);
   endtask

   task automatic test_dc_pos;
      sel = 1'b0; fill(1'b0, 1); run_block(0);
      nvec++;
      if (cap_dc !== 32'h0004_0000) begin nerr++; $display("FAIL dc_pos: got %h, need 00040000", cap_dc); end
      @(posedge clk); @(negedge clk);
      nvec++;
      if (m_busy !== 1'b0 || m_ready !== 1'b1) begin nerr++; $display("FAIL back_idle: busy %b ready %b, need 0/1", m_busy, m_ready); end
   endtask

   task automatic test_dc_neg;
      sel = 1'b0; fill(1'b0, -1); run_block(0);
      nvec++;
      if (cap_dc !== 32'hFFFC_0000) begin nerr++; $display("FAIL dc_neg: got %h, need fffc0000", cap_dc); end
   endtask

   task automatic test_gaps;
      sel = 1'b0; fill(1'b0, 1); run_block(1);
      nvec++;
      if (cap_dc !== 32'h0004_0000) begin nerr++; $display("FAIL dc_gaps: got %h, need 00040000", cap_dc); end
   endtask

   task automatic test_reset_mid;
      int r, bud;
      sel = 1'b0; fill(1'b0, 5);
      r = 0; bud = 50;
      while (r < 4 && bud > 0) begin
         vld = 1'b1; row = pack_row(r);
         if (m_ready) r++;
         bud--;
         @(posedge clk); @(negedge clk);
      end
      vld = 1'b0; rst = 1'b0;
      #1;
      nvec++;
      if (m_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_ready: got %b, need 0", m_ready); end
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      nvec++;
      if (m_busy !== 1'b0 || m_ov !== 1'b0) begin nerr++; $display("FAIL mid_rst_state: busy %b out_valid %b, need 0/0", m_busy, m_ov); end
      repeat (6) begin
         @(posedge clk); @(negedge clk);
         nvec++;
         if (m_ov !== 1'b0) begin nerr++; $display("FAIL aborted_out: out_valid=1 at cyc %0d", cyc); end
      end
      fill(1'b0, 1); run_block(0);
      nvec++;
      if (cap_dc !== 32'h0004_0000) begin nerr++; $display("FAIL dc_after_rst: got %h, need 00040000", cap_dc); end
   endtask

   task automatic test_random;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int b = 0; b < 3; b++) begin
            fill(1'b1, 0); run_block(2);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int a1, d1;
      sel = 1'b1; fill(1'b0, 1);
      run_block(0);
      a1 = acc0_cyc; d1 = done_cyc;
      nvec++;
      if (cap_dc !== 32'h0004_0000) begin nerr++; $display("FAIL b2b_dc1: got %h, need 00040000", cap_dc); end
      run_block(0);
      nvec++;
      if (cap_dc !== 32'h0004_0000) begin nerr++; $display("FAIL b2b_dc2: got %h, need 00040000", cap_dc); end
      nvec++;
      if (acc0_cyc != d1 + 1) begin nerr++; $display("FAIL b2b_accept: first accept at cyc %0d, need %0d", acc0_cyc, d1 + 1); end
      nvec++;
      if (acc0_cyc - a1 != 24) begin nerr++; $display("FAIL b2b_period: got %0d cycles, need 24", acc0_cyc - a1); end
   endtask

   initial begin
      test_reset;
      test_dc_pos;
      test_dc_neg;
      test_gaps;
      test_reset_mid;
      test_random;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
